cpu_bus_fabric: RTL and testbench

Parametrised CPU-side bus fabric for the NES core, replacing the single-slave bus wrapper around the 2 KB work RAM. It decodes one master request onto NUM_SLV slave ports using per-slave base/mask/offset windows, so address mirroring comes from configuration. It tracks each transfer with a small state machine, emulates open-bus reads for unmapped addresses, and terminates hung slave accesses with a timeout and an error pulse. It sits between the 6502 core's memory interface and the RAM, PPU, APU/IO and cartridge blocks.

---
 rtl/bus_pkg.sv | 26 ++
 rtl/bus_addr_decode.sv | 31 +++
 rtl/cpu_bus_fabric.sv | 186 ++++++++++++++++++
 tb/tb_cpu_bus_fabric.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the CPU-side bus fabric: transfer states,
// read/write encoding and the stock NES address windows.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // NES CPU map: 2 KB RAM mirrored below 0x2000, 8 PPU registers mirrored
  // through 0x3FFF, cartridge PRG space in the upper half.
  localparam logic [15:0] NES_RAM_BASE  = 16'h0000;
  localparam logic [15:0] NES_RAM_MASK  = 16'hE000;
  localparam logic [15:0] NES_RAM_OFFS  = 16'h07FF;
  localparam logic [15:0] NES_PPU_BASE  = 16'h2000;
  localparam logic [15:0] NES_PPU_MASK  = 16'hE000;
  localparam logic [15:0] NES_PPU_OFFS  = 16'h0007;
  localparam logic [15:0] NES_CART_BASE = 16'h8000;
  localparam logic [15:0] NES_CART_MASK = 16'h8000;
  localparam logic [15:0] NES_CART_OFFS = 16'h7FFF;

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational priority address decoder: lowest-index matching window wins,
// and the winning window's mirror mask is returned alongside the index.
module bus_addr_decode #(
  parameter int                       NUM_SLV  = 4,
  parameter int                       AW       = 16,
  parameter int                       SW       = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1,
  parameter logic [NUM_SLV*AW-1:0]    SLV_BASE = '0,
  parameter logic [NUM_SLV*AW-1:0]    SLV_MASK = '0,
  parameter logic [NUM_SLV*AW-1:0]    SLV_OFFS = '1
) (
  input  logic [AW-1:0] addr,
  output logic [SW-1:0] sel,
  output logic          hit,
  output logic [AW-1:0] offs
);

  // Scan from the top down so the lowest matching index is the last writer.
  always_comb begin
    sel  = '0;
    hit  = 1'b0;
    offs = '1;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if ((addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
        sel  = SW'(i);
        hit  = 1'b1;
        offs = SLV_OFFS[i*AW +: AW];
      end
    end
  end

endmodule

// File: rtl/cpu_bus_fabric.sv
// CPU-side bus fabric: decodes one master request onto NUM_SLV slaves, tracks
// the transfer, emulates open-bus reads and times out hung slaves.
module cpu_bus_fabric
  import bus_pkg::*;
#(
  parameter int                    NUM_SLV  = 4,
  parameter int                    AW       = 16,
  parameter int                    DW       = 8,
  parameter int                    TIMEOUT  = 15,
  parameter logic [NUM_SLV*AW-1:0] SLV_BASE = '0,
  parameter logic [NUM_SLV*AW-1:0] SLV_MASK = '0,
  parameter logic [NUM_SLV*AW-1:0] SLV_OFFS = '1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Cmd,
  input  logic                  RW,
  input  logic [AW-1:0]         Addr,
  input  logic [DW-1:0]         WData,
  output logic [DW-1:0]         RData,
  output logic                  Finish,
  output logic                  Busy,
  output logic                  Err,
  output logic [NUM_SLV-1:0]    s_cmd,
  output logic                  s_rw,
  output logic [AW-1:0]         s_addr,
  output logic [DW-1:0]         s_wdata,
  input  logic [NUM_SLV*DW-1:0] s_rdata,
  input  logic [NUM_SLV-1:0]    s_finish
);

  localparam int         SW      = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [SW-1:0] dec_sel;
  logic          dec_hit;
  logic [AW-1:0] dec_offs;

  bus_addr_decode #(
    .NUM_SLV  (NUM_SLV),
    .AW       (AW),
    .SW       (SW),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK),
    .SLV_OFFS (SLV_OFFS)
  ) u_decode (
    .addr (Addr),
    .sel  (dec_sel),
    .hit  (dec_hit),
    .offs (dec_offs)
  );

  state_t               state_q,   state_d;
  logic [SW-1:0]        sel_q,     sel_d;
  logic [7:0]           cnt_q,     cnt_d;
  logic [NUM_SLV-1:0]   s_cmd_q,   s_cmd_d;
  logic                 finish_q,  finish_d;
  logic                 err_q,     err_d;
  logic                 busy_q,    busy_d;
  logic [DW-1:0]        rdata_q,   rdata_d;
  logic [DW-1:0]        ob_q,      ob_d;
  logic                 s_rw_q,    s_rw_d;
  logic [AW-1:0]        s_addr_q,  s_addr_d;
  logic [DW-1:0]        s_wdata_q, s_wdata_d;

  logic                 sel_finish;
  logic [DW-1:0]        sel_rdata;

  // Only the latched slave's response is visible to the FSM.
  always_comb begin
    sel_finish = 1'b0;
    sel_rdata  = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (sel_q == SW'(i)) begin
        sel_finish = s_finish[i];
        sel_rdata  = s_rdata[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    s_cmd_d   = '0;
    finish_d  = 1'b0;
    err_d     = 1'b0;
    busy_d    = busy_q;
    rdata_d   = rdata_q;
    ob_d      = ob_q;
    s_rw_d    = s_rw_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (Cmd) begin
          s_rw_d    = RW;
          s_addr_d  = Addr & dec_offs;
          s_wdata_d = WData;
          sel_d     = dec_sel;
          cnt_d     = '0;
          busy_d    = 1'b1;
          if (dec_hit) begin
            state_d = ST_ACCESS;
            s_cmd_d = NUM_SLV'(1) << dec_sel;
          end else begin
            // Unmapped: reads see the open bus, writes are dropped but
            // still leave their data floating on the bus.
            state_d  = ST_DONE;
            finish_d = 1'b1;
            if (RW == RW_READ) rdata_d = ob_q;
            else               ob_d    = WData;
          end
        end
      end
      ST_ACCESS: begin
        if (sel_finish) begin
          state_d  = ST_DONE;
          finish_d = 1'b1;
          if (s_rw_q == RW_READ) begin
            rdata_d = sel_rdata;
            ob_d    = sel_rdata;
          end else begin
            ob_d    = s_wdata_q;
          end
        end else if (cnt_q == TO_LAST) begin
          state_d  = ST_DONE;
          finish_d = 1'b1;
          err_d    = 1'b1;
          if (s_rw_q == RW_READ) rdata_d = ob_q;
          else                   ob_d    = s_wdata_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      cnt_q     <= '0;
      s_cmd_q   <= '0;
      finish_q  <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      rdata_q   <= '0;
      ob_q      <= '0;
      s_rw_q    <= RW_READ;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      s_cmd_q   <= s_cmd_d;
      finish_q  <= finish_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      rdata_q   <= rdata_d;
      ob_q      <= ob_d;
      s_rw_q    <= s_rw_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
    end
  end

  assign RData   = rdata_q;
  assign Finish  = finish_q;
  assign Busy    = busy_q;
  assign Err     = err_q;
  assign s_cmd   = s_cmd_q;
  assign s_rw    = s_rw_q;
  assign s_addr  = s_addr_q;
  assign s_wdata = s_wdata_q;

endmodule

// File: tb/tb_cpu_bus_fabric.sv
// Directed bench for cpu_bus_fabric using the NES RAM/PPU/cart windows.
module tb_cpu_bus_fabric;

  logic        clk = 1'b0;
  logic        rst;
  logic        Cmd;
  logic        RW;
  logic [15:0] Addr;
  logic [7:0]  WData;
  logic [7:0]  RData;
  logic        Finish;
  logic        Busy;
  logic        Err;
  logic [2:0]  s_cmd;
  logic        s_rw;
  logic [15:0] s_addr;
  logic [7:0]  s_wdata;
  logic [23:0] s_rdata;
  logic [2:0]  s_finish;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cpu_bus_fabric #(
    .NUM_SLV  (3),
    .AW       (16),
    .DW       (8),
    .TIMEOUT  (15),
    .SLV_BASE ({16'h8000, 16'h2000, 16'h0000}),
    .SLV_MASK ({16'h8000, 16'hE000, 16'hE000}),
    .SLV_OFFS ({16'h7FFF, 16'h0007, 16'h07FF})
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .Cmd      (Cmd),
    .RW       (RW),
    .Addr     (Addr),
    .WData    (WData),
    .RData    (RData),
    .Finish   (Finish),
    .Busy     (Busy),
    .Err      (Err),
    .s_cmd    (s_cmd),
    .s_rw     (s_rw),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_rdata  (s_rdata),
    .s_finish (s_finish)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Cycle 0 carries Cmd; cycle c is observed at the c-th falling edge after it.
  // Slave slv (or none if negative) finishes in ACCESS cycle 1+waits.
  task automatic run_xfer(input logic rw, input logic [15:0] a, input logic [7:0] wd,
                          input int slv, input int waits,
                          output int fin_cyc, output logic fin_err, output logic [2:0] cmd_seen);
    fin_cyc  = -1;
    fin_err  = 1'b0;
    cmd_seen = '0;
    @(negedge clk);
    Cmd = 1'b1; RW = rw; Addr = a; WData = wd;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      Cmd = 1'b0;
      cmd_seen = cmd_seen | s_cmd;
      s_finish = '0;
      if (Finish) begin
        fin_cyc = c;
        fin_err = Err;
        break;
      end
      if (slv >= 0 && c == 1 + waits) s_finish[slv] = 1'b1;
    end
    s_finish = '0;
  endtask

  int          fc;
  logic        fe;
  logic [2:0]  cs;
  int          fins;
  logic        busy3;

  initial begin
    rst = 1'b1; Cmd = 1'b0; RW = 1'b1; Addr = '0; WData = '0;
    s_rdata = {8'hEE, 8'h11, 8'h5A}; s_finish = '0;
    repeat (2) @(negedge clk);
    chk("rst_rdata",  32'(RData),  32'h0);
    chk("rst_finish", 32'(Finish), 32'h0);
    chk("rst_err",    32'(Err),    32'h0);
    chk("rst_busy",   32'(Busy),   32'h0);
    chk("rst_s_cmd",  32'(s_cmd),  32'h0);
    chk("rst_s_rw",   32'(s_rw),   32'h1);
    chk("rst_s_addr", 32'(s_addr), 32'h0);
    rst = 1'b0;

    // Mirrored RAM read, zero-wait slave
    run_xfer(1'b1, 16'h1801, 8'h00, 0, 0, fc, fe, cs);
    chk("t1_s_cmd",  32'(cs),     32'h1);
    chk("t1_s_addr", 32'(s_addr), 32'h0001);
    chk("t1_s_rw",   32'(s_rw),   32'h1);
    chk("t1_fin",    32'(fc),     32'd2);
    chk("t1_err",    32'(fe),     32'h0);
    chk("t1_rdata",  32'(RData),  32'h5A);
    chk("t1_busy_fin", 32'(Busy), 32'h1);
    @(negedge clk);
    chk("t1_busy_after", 32'(Busy), 32'h0);

    // PPU mirror write with three wait states
    run_xfer(1'b0, 16'h3FFF, 8'hC3, 1, 3, fc, fe, cs);
    chk("t2_s_cmd",   32'(cs),      32'h2);
    chk("t2_s_addr",  32'(s_addr),  32'h0007);
    chk("t2_s_wdata", 32'(s_wdata), 32'hC3);
    chk("t2_s_rw",    32'(s_rw),    32'h0);
    chk("t2_fin",     32'(fc),      32'd5);
    chk("t2_err",     32'(fe),      32'h0);
    chk("t2_rdata",   32'(RData),   32'h5A);

    // Open bus: unmapped write then unmapped read, back to back
    run_xfer(1'b0, 16'h5000, 8'h77, -1, 0, fc, fe, cs);
    chk("t3w_fin",   32'(fc), 32'd1);
    chk("t3w_s_cmd", 32'(cs), 32'h0);
    run_xfer(1'b1, 16'h5000, 8'h00, -1, 0, fc, fe, cs);
    chk("t3r_fin",   32'(fc),    32'd1);
    chk("t3r_s_cmd", 32'(cs),    32'h0);
    chk("t3r_rdata", 32'(RData), 32'h77);

    // Timeout on the cartridge slave
    run_xfer(1'b1, 16'h8000, 8'h00, -1, 0, fc, fe, cs);
    chk("t4_s_cmd",  32'(cs),     32'h4);
    chk("t4_s_addr", 32'(s_addr), 32'h0000);
    chk("t4_fin",    32'(fc),     32'd16);
    chk("t4_err",    32'(fe),     32'h1);
    chk("t4_rdata",  32'(RData),  32'h77);
    run_xfer(1'b1, 16'h5000, 8'h00, -1, 0, fc, fe, cs);
    chk("t4_ob_kept", 32'(RData), 32'h77);
    chk("t4_err_clr", 32'(fe),    32'h0);

    // Cmd pulses during ACCESS are ignored
    s_rdata = {8'hEE, 8'h11, 8'h3C};
    fins = 0; fc = -1; busy3 = 1'b0;
    @(negedge clk);
    Cmd = 1'b1; RW = 1'b1; Addr = 16'h0005;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (Finish) begin
        fins++;
        if (fc < 0) fc = c;
      end
      if (c == 3) busy3 = Busy;
      Cmd = (c == 2 || c == 3);
      if (c == 2) Addr = 16'h5000;
      s_finish = (c == 5) ? 3'b001 : 3'b000;
    end
    Cmd = 1'b0;
    chk("t5_fin_count", 32'(fins),   32'd1);
    chk("t5_fin",       32'(fc),     32'd6);
    chk("t5_busy",      32'(busy3),  32'h1);
    chk("t5_rdata",     32'(RData),  32'h3C);
    chk("t5_s_addr",    32'(s_addr), 32'h0005);

    // Reset in the middle of an ACCESS
    @(negedge clk);
    Cmd = 1'b1; RW = 1'b1; Addr = 16'h8001;
    @(negedge clk);
    Cmd = 1'b0;
    chk("t6_s_cmd", 32'(s_cmd), 32'h4);
    repeat (2) @(negedge clk);
    chk("t6_busy_pre", 32'(Busy), 32'h1);
    rst = 1'b1;
    #1;
    chk("t6_busy",   32'(Busy),   32'h0);
    chk("t6_finish", 32'(Finish), 32'h0);
    chk("t6_err",    32'(Err),    32'h0);
    chk("t6_rdata",  32'(RData),  32'h0);
    chk("t6_s_cmd0", 32'(s_cmd),  32'h0);
    chk("t6_s_addr", 32'(s_addr), 32'h0);
    chk("t6_s_rw",   32'(s_rw),   32'h1);
    @(negedge clk);
    rst = 1'b0;
    fins = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (Finish) fins++;
    end
    chk("t6_no_finish", 32'(fins), 32'd0);
    run_xfer(1'b1, 16'h5000, 8'h00, -1, 0, fc, fe, cs);
    chk("t6_ob_reset", 32'(RData), 32'h0);
    chk("t6_fin",      32'(fc),    32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
